// File: rtl/gift_round_ctrl_pkg.sv
// Shared definitions for the GIFT-128 round controller: state encoding,
// round-count and round-constant parameters, and the constant update rule.
package gift_round_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int GIFT128_ROUNDS = 40;
    localparam int RC_WIDTH       = 6;
    localparam logic [RC_WIDTH-1:0] RC_INIT = 6'h01;

    // GIFT round-constant update: shift left, feed back c5 ^ c4 ^ 1.
    function automatic logic [RC_WIDTH-1:0] rc_step(input logic [RC_WIDTH-1:0] c);
        return {c[4:0], c[5] ^ c[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/gift_rc_lfsr.sv
// 6-bit GIFT round-constant LFSR. init loads the first constant, step advances
// one round; otherwise the value holds.
module gift_rc_lfsr
    import gift_round_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                init_i,
    input  logic                step_i,
    output logic [RC_WIDTH-1:0] rc_o
);

    logic [RC_WIDTH-1:0] rc_q;
    logic [RC_WIDTH-1:0] rc_d;

    // Next constant: init has priority over step.
    always_comb begin
        rc_d = rc_q;
        if (init_i) begin
            rc_d = RC_INIT;
        end else if (step_i) begin
            rc_d = rc_step(rc_q);
        end
    end

    // Constant register, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rc_q <= '0;
        end else begin
            rc_q <= rc_d;
        end
    end

    assign rc_o = rc_q;

endmodule

// File: rtl/gift_round_ctrl.sv
// GIFT-128 round controller: sequences LOAD, ROUNDS round cycles, WRITE and a
// DONE pulse per block. All outputs are Moore decodes of the registered state.
module gift_round_ctrl
    import gift_round_ctrl_pkg::*;
#(
    parameter int ROUNDS = GIFT128_ROUNDS
) (
    input  logic                inClk,
    input  logic                inRstN,
    input  logic                inStart,
    input  logic                inAbort,
    output logic                outLoad,
    output logic                outRoundEn,
    output logic [5:0]          outRoundIdx,
    output logic [RC_WIDTH-1:0] outRoundConst,
    output logic                outOutWr,
    output logic                outBusy,
    output logic                outDone
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_e              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [RC_WIDTH-1:0] rc;

    // State and round counter registers.
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; abort dominates every state, including a start request.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: state_d = (inStart && !inAbort) ? ST_LOAD : ST_IDLE;
            ST_LOAD:          state_d = inAbort ? ST_IDLE : ST_ROUND;
            ST_ROUND: begin
                if (inAbort)               state_d = ST_IDLE;
                else if (cnt_q == LAST_IDX) state_d = ST_WRITE;
                else                        state_d = ST_ROUND;
            end
            ST_WRITE:         state_d = inAbort ? ST_IDLE : ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Round counter: cleared while loading, advanced once per round cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_LOAD) begin
            cnt_d = '0;
        end else if (state_q == ST_ROUND) begin
            cnt_d = cnt_q + 6'd1;
        end
    end

    gift_rc_lfsr u_rc (
        .clk_i  (inClk),
        .rst_ni (inRstN),
        .init_i (state_q == ST_LOAD),
        .step_i (state_q == ST_ROUND),
        .rc_o   (rc)
    );

    // Output decode of the current state; index and constant masked outside rounds.
    always_comb begin
        outLoad       = 1'b0;
        outRoundEn    = 1'b0;
        outRoundIdx   = '0;
        outRoundConst = '0;
        outOutWr      = 1'b0;
        outBusy       = 1'b0;
        outDone       = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                outLoad = 1'b1;
                outBusy = 1'b1;
            end
            ST_ROUND: begin
                outRoundEn    = 1'b1;
                outRoundIdx   = cnt_q;
                outRoundConst = rc;
                outBusy       = 1'b1;
            end
            ST_WRITE: begin
                outOutWr = 1'b1;
                outBusy  = 1'b1;
            end
            ST_DONE:  outDone = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_gift_round_ctrl.sv
// Bench for gift_round_ctrl: default (40-round) and 1-round instances driven
// in parallel, compared every cycle against a block-timeline reference model.
module tb_gift_round_ctrl;

    logic inClk, inRstN, inStart, inAbort;

    logic       a_load, a_en, a_wr, a_busy, a_done;
    logic [5:0] a_idx, a_rc;
    logic       b_load, b_en, b_wr, b_busy, b_done;
    logic [5:0] b_idx, b_rc;

    int total = 0;
    int bad   = 0;

    // Model: position in the block timeline. -1 = not in a block,
    // 0 = load, 1..R = round R-1, R+1 = write, R+2 = done.
    int pos_a = -1;
    int pos_b = -1;
    int rc_tab [64];
    int cyc_n = 0;
    int last_load = -1;
    bit track_gap = 0;
    int lit [8];

    gift_round_ctrl u_dut_a (
        .inClk(inClk), .inRstN(inRstN), .inStart(inStart), .inAbort(inAbort),
        .outLoad(a_load), .outRoundEn(a_en), .outRoundIdx(a_idx),
        .outRoundConst(a_rc), .outOutWr(a_wr), .outBusy(a_busy), .outDone(a_done)
    );

    gift_round_ctrl #(.ROUNDS(1)) u_dut_b (
        .inClk(inClk), .inRstN(inRstN), .inStart(inStart), .inAbort(inAbort),
        .outLoad(b_load), .outRoundEn(b_en), .outRoundIdx(b_idx),
        .outRoundConst(b_rc), .outOutWr(b_wr), .outBusy(b_busy), .outDone(b_done)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int pos, input int r, input bit s, input bit a);
        if (a) return -1;
        if (pos == -1 || pos == r + 2) return s ? 0 : -1;
        return pos + 1;
    endfunction

    task automatic check_outs(input string who, input int pos, input int r,
                              input logic ld, input logic en, input logic [5:0] idx,
                              input logic [5:0] rc, input logic wr, input logic busy,
                              input logic dn);
        int e_en;
        e_en = (pos >= 1 && pos <= r) ? 1 : 0;
        chk({who, "_load"}, 32'(ld),   (pos == 0) ? 1 : 0);
        chk({who, "_ren"},  32'(en),   e_en);
        chk({who, "_idx"},  32'(idx),  e_en ? pos - 1 : 0);
        chk({who, "_rc"},   32'(rc),   e_en ? rc_tab[pos - 1] : 0);
        chk({who, "_wr"},   32'(wr),   (pos == r + 1) ? 1 : 0);
        chk({who, "_busy"}, 32'(busy), (pos >= 0 && pos <= r + 1) ? 1 : 0);
        chk({who, "_done"}, 32'(dn),   (pos == r + 2) ? 1 : 0);
        chk({who, "_onehot"}, 32'(int'(ld) + int'(en) + int'(wr) + int'(dn) <= 1), 1);
    endtask

    // One clock cycle: check outputs at the falling edge, drive inputs, advance model.
    task automatic cyc(input bit s, input bit a);
        @(negedge inClk);
        check_outs("r40", pos_a, 40, a_load, a_en, a_idx, a_rc, a_wr, a_busy, a_done);
        check_outs("r1",  pos_b, 1,  b_load, b_en, b_idx, b_rc, b_wr, b_busy, b_done);
        if (pos_a >= 1 && pos_a <= 8) chk("rc_literal", 32'(a_rc), lit[pos_a - 1]);
        if (pos_a == 40) chk("rc_round39", 32'(a_rc), 32'h1a);
        if (track_gap && a_load === 1'b1) begin
            if (last_load >= 0) chk("load_gap", cyc_n - last_load, 43);
            last_load = cyc_n;
        end
        inStart = s;
        inAbort = a;
        @(posedge inClk);
        cyc_n++;
        if (!inRstN) begin
            pos_a = -1;
            pos_b = -1;
        end else begin
            pos_a = nxt(pos_a, 40, s, a);
            pos_b = nxt(pos_b, 1, s, a);
        end
    endtask

    initial begin
        int c;
        c = 1;
        for (int i = 0; i < 64; i++) begin
            rc_tab[i] = c;
            c = ((c << 1) & 'h3e) | (((c >> 5) ^ (c >> 4) ^ 1) & 1);
        end
        lit[0] = 'h01; lit[1] = 'h03; lit[2] = 'h07; lit[3] = 'h0f;
        lit[4] = 'h1f; lit[5] = 'h3e; lit[6] = 'h3d; lit[7] = 'h3b;

        // Reset held, then released away from the clock edge.
        inRstN  = 1'b0;
        inStart = 1'b0;
        inAbort = 1'b0;
        repeat (3) cyc(1, 0);
        #2 inRstN = 1'b1;

        // Single block followed by idle time.
        cyc(1, 0);
        repeat (46) cyc(0, 0);

        // Start held high: restarts only from DONE, loads 43 cycles apart.
        track_gap = 1;
        repeat (100) cyc(1, 0);
        track_gap = 0;
        repeat (46) cyc(0, 0);

        // Abort at round index 20, then restart.
        cyc(1, 0);
        for (int i = 0; i < 100 && pos_a != 21; i++) cyc(0, 0);
        cyc(0, 1);
        repeat (3) cyc(0, 0);
        cyc(1, 0);
        repeat (46) cyc(0, 0);

        // Start and abort together while idle: no load.
        cyc(1, 1);
        repeat (3) cyc(0, 0);

        // Abort during the write cycle: strobe seen, no done.
        cyc(1, 0);
        for (int i = 0; i < 100 && pos_a != 41; i++) cyc(0, 0);
        cyc(0, 1);
        repeat (3) cyc(0, 0);

        // Asynchronous reset at round index 10.
        cyc(1, 0);
        for (int i = 0; i < 100 && pos_a != 11; i++) cyc(0, 0);
        #2 inRstN = 1'b0;
        #1;
        chk("rst_load", 32'(a_load), 0);
        chk("rst_ren",  32'(a_en),   0);
        chk("rst_idx",  32'(a_idx),  0);
        chk("rst_rc",   32'(a_rc),   0);
        chk("rst_wr",   32'(a_wr),   0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        pos_a = -1;
        pos_b = -1;
        cyc(0, 0);
        #2 inRstN = 1'b1;
        repeat (46) cyc(0, 0);

        // Randomized starts and occasional aborts.
        for (int i = 0; i < 700; i++) begin
            cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3);
        end
        repeat (2) cyc(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
